// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its skid buffer.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundles the imem request/response, redirect/stall and IF/ID-facing signals of the fetch sequencer.
interface fetch_sequencer_if #(
  parameter int PC_W = 32
);
  import fetch_pkg::*;

  logic               imem_req_valid;
  logic [PC_W-1:0]    imem_req_addr;
  logic               imem_req_ready;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               stall;
  logic               if_valid;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, stall
  );

endinterface

// File: rtl/fetch_skid.sv
// One-entry {pc, instr} holding buffer for a response that arrives while IF/ID is stalled.
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               full_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               full_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;

  // Flush wins over a simultaneous load so a redirect never leaves a stale entry behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (flush_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q  <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (unload_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o  = full_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, issues one imem read at a time and presents returned instructions to IF/ID.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_sequencer_if.master    bus
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
  localparam logic [PC_W-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               req_valid_q, req_valid_d;
  logic               if_valid_q, if_valid_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;

  logic               consumed;
  logic               skid_load, skid_unload, skid_full;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;

  assign consumed = if_valid_q && !bus.stall;

  fetch_skid #(.PC_W(PC_W)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .flush_i  (bus.redirect_valid),
    .pc_i     (pc_q),
    .instr_i  (bus.imem_rsp_data),
    .full_o   (skid_full),
    .pc_o     (skid_pc),
    .instr_o  (skid_instr)
  );

  // Redirect overrides everything; a request already accepted must have its response dropped.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_valid_d  = consumed ? 1'b0 : if_valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;

    if (bus.redirect_valid) begin
      pc_d       = bus.redirect_pc & ALIGN_MASK;
      if_valid_d = 1'b0;
      unique case (state_q)
        REQ:     state_d = bus.imem_req_ready ? DROP : REQ;
        WAIT:    state_d = bus.imem_rsp_valid ? REQ : DROP;
        DROP:    state_d = bus.imem_rsp_valid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ:  if (bus.imem_req_ready) state_d = WAIT;
        WAIT: begin
          if (bus.imem_rsp_valid) begin
            pc_d = pc_q + PC_W'(PC_STEP);
            if (!if_valid_q || !bus.stall) begin
              if_valid_d = 1'b1;
              if_pc_d    = pc_q;
              if_instr_d = bus.imem_rsp_data;
              state_d    = skid_full ? HOLD : REQ;
            end else begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            skid_unload = 1'b1;
            if_valid_d  = 1'b1;
            if_pc_d     = skid_pc;
            if_instr_d  = skid_instr;
            state_d     = REQ;
          end
        end
        DROP: if (bus.imem_rsp_valid) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end

    req_valid_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC_A;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = if_instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer: free run, stall/skid, redirects, PC wrap and reset.
module tb_fetch_sequencer;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  fetch_sequencer_if #(.PC_W(32)) bus ();

  fetch_sequencer #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic redv, input logic [31:0] rpc, input logic st);
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    bus.redirect_valid = redv;
    bus.redirect_pc    = rpc;
    bus.stall          = st;
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in REQ for RESET_PC, one edge after reset release.
  task automatic applyReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
    compared++; if (bus.imem_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_req_valid: got %b want 0", bus.imem_req_valid); end
    compared++; if (bus.imem_req_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_req_addr: got %h want 00000000", bus.imem_req_addr); end
    compared++; if (bus.if_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_if_valid: got %b want 0", bus.if_valid); end
    rst_n = 1'b1;
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
    compared++; if (bus.imem_req_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL idle_to_req: got %b want 1", bus.imem_req_valid); end
  endtask

  task automatic test_free_run();
    applyReset();
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    compared++; if (bus.imem_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL run_wait0_valid: got %b want 0", bus.imem_req_valid); end
    applyStimulus(0, 1, 32'hA000_0000, 0, 32'h0, 0);
    compared++; if (bus.if_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL run_if_valid0: got %b want 1", bus.if_valid); end
    compared++; if (bus.if_pc !== 32'h0) begin mismatched++; $display("[TB] FAIL run_if_pc0: got %h want 00000000", bus.if_pc); end
    compared++; if (bus.if_instr !== 32'hA000_0000) begin mismatched++; $display("[TB] FAIL run_if_instr0: got %h want a0000000", bus.if_instr); end
    compared++; if (bus.imem_req_addr !== 32'h4) begin mismatched++; $display("[TB] FAIL run_addr4: got %h want 00000004", bus.imem_req_addr); end
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    compared++; if (bus.if_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL run_consumed0: got %b want 0", bus.if_valid); end
    applyStimulus(0, 1, 32'hA000_0004, 0, 32'h0, 0);
    compared++; if (bus.if_pc !== 32'h4) begin mismatched++; $display("[TB] FAIL run_if_pc4: got %h want 00000004", bus.if_pc); end
    compared++; if (bus.imem_req_addr !== 32'h8) begin mismatched++; $display("[TB] FAIL run_addr8: got %h want 00000008", bus.imem_req_addr); end
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'hA000_0008, 0, 32'h0, 0);
    compared++; if (bus.if_pc !== 32'h8) begin mismatched++; $display("[TB] FAIL run_if_pc8: got %h want 00000008", bus.if_pc); end
    compared++; if (bus.if_instr !== 32'hA000_0008) begin mismatched++; $display("[TB] FAIL run_if_instr8: got %h want a0000008", bus.if_instr); end
    compared++; if (bus.imem_req_addr !== 32'hC) begin mismatched++; $display("[TB] FAIL run_addrC: got %h want 0000000c", bus.imem_req_addr); end
  endtask

  task automatic test_stall_hold();
    applyReset();
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'hB000_0000, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'hB000_0004, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
    compared++; if (bus.if_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_keep_valid: got %b want 1", bus.if_valid); end
    applyStimulus(0, 1, 32'hB000_0008, 0, 32'h0, 1);
    compared++; if (bus.if_pc !== 32'h4) begin mismatched++; $display("[TB] FAIL stall_if_pc: got %h want 00000004", bus.if_pc); end
    compared++; if (bus.if_instr !== 32'hB000_0004) begin mismatched++; $display("[TB] FAIL stall_if_instr: got %h want b0000004", bus.if_instr); end
    compared++; if (bus.imem_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_no_req: got %b want 0", bus.imem_req_valid); end
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
    compared++; if (bus.imem_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_still_no_req: got %b want 0", bus.imem_req_valid); end
    compared++; if (bus.if_pc !== 32'h4) begin mismatched++; $display("[TB] FAIL hold_if_pc: got %h want 00000004", bus.if_pc); end
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
    compared++; if (bus.if_pc !== 32'h8) begin mismatched++; $display("[TB] FAIL unload_if_pc: got %h want 00000008", bus.if_pc); end
    compared++; if (bus.if_instr !== 32'hB000_0008) begin mismatched++; $display("[TB] FAIL unload_if_instr: got %h want b0000008", bus.if_instr); end
    compared++; if (bus.if_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL unload_if_valid: got %b want 1", bus.if_valid); end
    compared++; if (bus.imem_req_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL unload_req_valid: got %b want 1", bus.imem_req_valid); end
    compared++; if (bus.imem_req_addr !== 32'hC) begin mismatched++; $display("[TB] FAIL unload_req_addr: got %h want 0000000c", bus.imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    applyReset();
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'hC000_0000, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'hC000_0004, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
    applyStimulus(0, 0, 32'h0, 1, 32'h0000_0100, 1);
    compared++; if (bus.if_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL redir_flush: got %b want 0", bus.if_valid); end
    compared++; if (bus.imem_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL redir_drop_noreq: got %b want 0", bus.imem_req_valid); end
    applyStimulus(0, 1, 32'hDEAD_0008, 0, 32'h0, 0);
    compared++; if (bus.if_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_discard: got %b want 0", bus.if_valid); end
    compared++; if (bus.imem_req_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_to_req: got %b want 1", bus.imem_req_valid); end
    compared++; if (bus.imem_req_addr !== 32'h100) begin mismatched++; $display("[TB] FAIL redir_addr: got %h want 00000100", bus.imem_req_addr); end
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'hC000_0100, 0, 32'h0, 0);
    compared++; if (bus.if_pc !== 32'h100) begin mismatched++; $display("[TB] FAIL redir_if_pc: got %h want 00000100", bus.if_pc); end
    compared++; if (bus.if_instr !== 32'hC000_0100) begin mismatched++; $display("[TB] FAIL redir_if_instr: got %h want c0000100", bus.if_instr); end
  endtask

  task automatic test_redirect_same_cycle();
    applyReset();
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'hE000_0000, 1, 32'h0000_0203, 0);
    compared++; if (bus.if_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL same_discard: got %b want 0", bus.if_valid); end
    compared++; if (bus.imem_req_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL same_no_drop: got %b want 1", bus.imem_req_valid); end
    compared++; if (bus.imem_req_addr !== 32'h200) begin mismatched++; $display("[TB] FAIL same_align: got %h want 00000200", bus.imem_req_addr); end
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'hE000_0200, 0, 32'h0, 0);
    compared++; if (bus.if_pc !== 32'h200) begin mismatched++; $display("[TB] FAIL same_if_pc: got %h want 00000200", bus.if_pc); end
  endtask

  task automatic test_redirect_accept();
    applyReset();
    applyStimulus(1, 0, 32'h0, 1, 32'h0000_0040, 0);
    compared++; if (bus.imem_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL accept_drop: got %b want 0", bus.imem_req_valid); end
    applyStimulus(0, 1, 32'hDEAD_0000, 0, 32'h0, 0);
    compared++; if (bus.if_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL accept_discard: got %b want 0", bus.if_valid); end
    compared++; if (bus.imem_req_addr !== 32'h40) begin mismatched++; $display("[TB] FAIL accept_addr: got %h want 00000040", bus.imem_req_addr); end
  endtask

  task automatic test_wrap();
    applyReset();
    applyStimulus(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0);
    compared++; if (bus.imem_req_addr !== 32'hFFFF_FFFC) begin mismatched++; $display("[TB] FAIL wrap_top_addr: got %h want fffffffc", bus.imem_req_addr); end
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'hF000_FFFC, 0, 32'h0, 0);
    compared++; if (bus.if_pc !== 32'hFFFF_FFFC) begin mismatched++; $display("[TB] FAIL wrap_if_pc: got %h want fffffffc", bus.if_pc); end
    compared++; if (bus.imem_req_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL wrap_addr: got %h want 00000000", bus.imem_req_addr); end
  endtask

  task automatic test_reset_mid();
    applyReset();
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 32'h9000_0000, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0, 0, 32'h0, 1);
    rst_n = 1'b0;
    #2;
    compared++; if (bus.if_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_if_valid: got %b want 0", bus.if_valid); end
    compared++; if (bus.if_instr !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_if_instr: got %h want 00000000", bus.if_instr); end
    compared++; if (bus.imem_req_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_req_addr: got %h want 00000000", bus.imem_req_addr); end
    compared++; if (bus.imem_req_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_req_valid: got %b want 0", bus.imem_req_valid); end
    applyStimulus(0, 0, 32'h0, 0, 32'h0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 1, 32'h9000_0004, 0, 32'h0, 0);
    compared++; if (bus.if_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_stray_ignored: got %b want 0", bus.if_valid); end
    compared++; if (bus.imem_req_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_first_req: got %b want 1", bus.imem_req_valid); end
    compared++; if (bus.imem_req_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_first_addr: got %h want 00000000", bus.imem_req_addr); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.stall          = 1'b0;
    #2;
    test_reset();
    test_free_run();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_redirect_accept();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that owns the program counter (PC) and sequences instruction-memory reads. It issues one request at a time over a valid/ready handshake and buffers returned instructions toward the IF/ID register. It honours pipeline stalls and applies branch/jump redirects, which are the taken-branch or jump target computed by the next-PC logic in EX. It sits between the imem port and IF/ID and replaces the free-running PC register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_W, 32, PC and address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  PC_W  fetch address, word-aligned
imem_req_ready  in  1  imem accepts the request this cycle
imem_rsp_valid  in  1  instruction data valid; arrives at least 1 cycle after acceptance
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  one-cycle pulse: taken branch or jump
redirect_pc  in  PC_W  redirect target
stall  in  1  IF/ID holding; the current if_* is not consumed
if_valid  out  1  if_pc/if_instr hold a live instruction
if_pc  out  PC_W  PC of the presented instruction
if_instr  out  32  presented instruction

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - pc=RESET_PC, state=IDLE.
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - if_valid=0, if_pc=0, if_instr=0; skid buffer empty.
- Consumption: if_* is consumed in any cycle with if_valid=1 and stall=0.
- All outputs are registered. imem_req_addr=pc, with bits [1:0] always 0.
- States:
  - IDLE: first clock after reset release goes to REQ.
  - REQ: imem_req_valid=1.
    - On imem_req_ready, go to WAIT.
    - REQ is entered only if the skid buffer is empty; otherwise go to HOLD.
  - WAIT: request outstanding, imem_req_valid=0. On imem_rsp_valid:
    - If the output slot is empty or consumed this cycle: if_instr<=rsp_data, if_pc<=pc, if_valid<=1; go to REQ.
    - Else (slot full and stall=1): capture {pc, rsp_data} into the skid buffer; go to HOLD.
    - In both cases pc<=pc+4.
  - HOLD: no request issued. When stall=0, the skid entry moves into the output slot next cycle and the skid empties; go to REQ.
  - DROP: a stale response is pending. Discard the next imem_rsp_valid (no output change), then go to REQ.
- Single outstanding request only. Back-to-back throughput is 1 instruction per 2 cycles with a 1-cycle imem.
- PC increment wraps modulo 2^PC_W (32'hFFFF_FFFC+4 = 0).
- Redirect has priority over stall and over response capture. When redirect_valid=1, next cycle:
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - if_valid<=0 and the skid buffer is emptied (flush).
  - Next state by current state:
    - IDLE or REQ, not accepted this cycle: go to REQ with the new address. imem_req_addr may change while valid only on redirect.
    - REQ with imem_req_ready in the same cycle: the old request is in flight; go to DROP.
    - WAIT without rsp_valid: go to DROP.
    - WAIT with rsp_valid in the same cycle: discard the response; go to REQ.
    - HOLD: go to REQ.
    - DROP: stay in DROP. A response in the same cycle is discarded; DROP then still expects none, so go to REQ if a response arrived, else stay in DROP.
- Stall without redirect never alters if_*. Stall does not block an outstanding response; that response lands in the skid buffer.
- Reset mid-operation: immediate return to reset values. Any in-flight imem response after reset release is ignored, because IDLE ignores imem_rsp_valid.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum {IDLE, REQ, WAIT, HOLD, DROP}
  - RESET_PC default
  - INSTR_W=32
  - PC_STEP=4
- One sub-module, fetch_skid: a 1-entry {pc, instr} buffer with load, unload and flush inputs and a full output. The FSM and PC stay in fetch_sequencer.

Test Plan:
- Reset then free run with ready=1 and a 1-cycle response → if_pc sequence 0x0, 0x4, 0x8 with if_valid pulses every 2 cycles; imem_req_addr matches.
- Stall held high from the cycle if_pc=0x4 is presented, response for 0x8 returns → state HOLD, if_pc stays 0x4, no new request. Release stall → if_pc=0x8 next cycle, then a request to 0xC.
- Redirect to 0x100 while WAIT for 0x8 → if_valid=0 next cycle, the 0x8 response is discarded, next request addr=0x100, then if_pc=0x100.
- Redirect to 0x203 in the same cycle as rsp_valid → the response is dropped, request addr=0x200 (low bits forced), no DROP state entered.
- pc=0xFFFF_FFFC fetched → next request addr=0x0000_0000.
- rst_n low for 1 cycle while WAIT → all outputs are at reset values during the reset; after release, a stray rsp_valid is ignored and the first request is to RESET_PC.
